// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
//   Responder side of the cache miss interface. Converts cache line refills
//   (rd_req) and writebacks (wr_req) into AXI4 INCR bursts on a 32-bit master
//   port, and streams read data back to the cache one word per beat.
//   One read and one write may be outstanding at a time. A read to the same
//   16-byte line as an in-flight write is held off until that write's
//   B handshake completes.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   rd_req/rd_type/rd_addr/rd_rdy  cache read request channel
//   ret_valid/ret_data/ret_last    read return words to the cache
//   wr_req/wr_type/wr_addr/
//   wr_wstrb/wr_data/wr_rdy        cache write request channel
//   ar*/r*                         AXI4 read address / read data channels
//   aw*/w*/b*                      AXI4 write address / data / response channels
module cache_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         rst,
  // cache read side
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [31:0]  ret_data,
  output logic         ret_last,
  // cache write side
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  // AXI read address
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  // AXI read data
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  // AXI write address
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  // AXI write data
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  // AXI write response
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;

  rd_state_t rd_state;
  wr_state_t wr_state;

  // read-side registers
  logic [31:0]  ar_addr_q;
  logic [7:0]   ar_len_q;
  logic         arvalid_q;
  logic         rready_q;

  // write-side registers
  logic [31:0]  wr_addr_q;
  logic [127:0] wr_data_q;
  logic [3:0]   wr_strb_q;
  logic         wr_line_q;
  logic [1:0]   beat_q;
  logic         aw_done_q;
  logic         w_done_q;
  logic         awvalid_q;
  logic         wvalid_q;
  logic         bready_q;

  logic         conflict;
  logic         aw_hs;
  logic         w_hs;
  logic         aw_fin;
  logic         w_fin;

  // Response ids and codes carry no information this bridge acts on.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, bid, bresp};

  // A read may not overtake a writeback to the same line; the data in
  // memory is stale until the write response arrives.
  assign conflict = (wr_state != W_IDLE) && (rd_addr[31:4] == wr_addr_q[31:4]);

  assign rd_rdy    = (rd_state == R_IDLE) && !conflict;
  assign wr_rdy    = (wr_state == W_IDLE);

  assign arid      = RD_ID;
  assign araddr    = ar_addr_q;
  assign arlen     = ar_len_q;
  assign arsize    = 3'd2;
  assign arburst   = 2'b01;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

  // rready is high exactly while in R_DATA, so it also qualifies the return.
  assign ret_valid = rready_q & rvalid;
  assign ret_data  = rdata;
  assign ret_last  = rready_q & rlast;

  assign awid      = WR_ID;
  assign awaddr    = wr_line_q ? {wr_addr_q[31:4], 4'b0000} : wr_addr_q;
  assign awlen     = wr_line_q ? 8'd3 : 8'd0;
  assign awsize    = 3'd2;
  assign awburst   = 2'b01;
  assign awvalid   = awvalid_q;

  assign wdata     = wr_data_q[{beat_q, 5'b00000} +: 32];
  assign wstrb     = wr_line_q ? 4'hf : wr_strb_q;
  assign wlast     = (beat_q == awlen[1:0]);
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;

  // AW and W complete independently; a channel counts as finished if it
  // was already done or handshakes this cycle, so simultaneous completion
  // still advances to W_RESP in one step.
  assign aw_hs  = awvalid_q & awready;
  assign w_hs   = wvalid_q & wready;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | (w_hs & wlast);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_req && rd_rdy) begin
            if (rd_type == TYPE_LINE) begin
              ar_addr_q <= {rd_addr[31:4], 4'b0000};
              ar_len_q  <= 8'd3;
            end else begin
              ar_addr_q <= rd_addr;
              ar_len_q  <= 8'd0;
            end
            arvalid_q <= 1'b1;
            rd_state  <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            rd_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rlast) begin
            rready_q <= 1'b0;
            rd_state <= R_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          rd_state  <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      beat_q    <= 2'd0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_req) begin
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
            wr_strb_q <= wr_wstrb;
            wr_line_q <= (wr_type == TYPE_LINE);
            beat_q    <= 2'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            wr_state  <= W_XFER;
          end
        end
        W_XFER: begin
          if (aw_hs) begin
            aw_done_q <= 1'b1;
            awvalid_q <= 1'b0;
          end
          if (w_hs) begin
            beat_q <= beat_q + 2'd1;
            if (wlast) begin
              w_done_q <= 1'b1;
              wvalid_q <= 1'b0;
            end
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          wr_state  <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge
//   Scoreboard bench for cache_axi_bridge. Scenario code pushes expected AR,
//   AW, W and return-word transactions into queues; a monitor process pops
//   and compares whenever the DUT presents a handshake or a return word.
//   Timing-sensitive properties (reset values, stalls, conflict, reset in
//   mid-burst) are checked inline by the scenario code.
`timescale 1ns/1ps
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_type = 3'b100;
  logic [31:0]  rd_addr = '0;
  logic         rd_rdy;
  logic         ret_valid;
  logic [31:0]  ret_data;
  logic         ret_last;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = 3'b100;
  logic [31:0]  wr_addr = '0;
  logic [3:0]   wr_wstrb = 4'hf;
  logic [127:0] wr_data = '0;
  logic         wr_rdy;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [3:0]   rid = 4'd0;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = 2'b00;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready = 1'b0;
  logic [3:0]   bid = 4'd1;
  logic [1:0]   bresp = 2'b00;
  logic         bvalid = 1'b0;
  logic         bready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } addr_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } ret_exp_t;

  addr_exp_t exp_ar[$];
  addr_exp_t exp_aw[$];
  w_exp_t    exp_w[$];
  ret_exp_t  exp_ret[$];

  localparam int SIG_RREADY = 0;
  localparam int SIG_BREADY = 1;

  cache_axi_bridge #(.RD_ID(4'd0), .WR_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data), .ret_last(ret_last),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  function automatic logic sig(input int which);
    case (which)
      SIG_RREADY: return rready;
      SIG_BREADY: return bready;
      default:    return 1'b0;
    endcase
  endfunction

  // Returns at negedge+1 with the selected signal high, or records a timeout.
  task automatic waitFor(input int which, input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sig(which)) return;
      @(negedge clk);
      #1;
    end
    failNow(name, "timed out waiting for handshake");
  endtask

  // AXI read slave: streams n words base, base+1, ... once rready is up.
  task automatic rSlave(input logic [31:0] base, input int n);
    waitFor(SIG_RREADY, "rready_wait", 20);
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1;
      rdata  = base + 32'(i);
      rlast  = (i == n - 1);
      exp_ret.push_back('{base + 32'(i), (i == n - 1)});
      @(negedge clk);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  // AXI write response slave: one bvalid pulse once bready is up.
  task automatic bSlave();
    waitFor(SIG_BREADY, "bready_wait", 40);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  task automatic writeFinish();
    awready = 1'b1;
    wready  = 1'b1;
    bSlave();
    awready = 1'b0;
    wready  = 1'b0;
  endtask

  // Monitor: compares every handshake against the scoreboard queues.
  initial begin
    addr_exp_t a;
    w_exp_t    w;
    ret_exp_t  r;
    forever begin
      @(negedge clk);
      #2;
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) failNow("ar_unexpected", $sformatf("got araddr 0x%0h, required none", araddr));
        else begin
          a = exp_ar.pop_front();
          checkOutput("araddr", 64'(araddr), 64'(a.addr));
          checkOutput("arlen", 64'(arlen), 64'(a.len));
          checkOutput("arid", 64'(arid), 64'(a.id));
          checkOutput("arsize", 64'(arsize), 64'(3'd2));
          checkOutput("arburst", 64'(arburst), 64'(2'b01));
        end
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) failNow("aw_unexpected", $sformatf("got awaddr 0x%0h, required none", awaddr));
        else begin
          a = exp_aw.pop_front();
          checkOutput("awaddr", 64'(awaddr), 64'(a.addr));
          checkOutput("awlen", 64'(awlen), 64'(a.len));
          checkOutput("awid", 64'(awid), 64'(a.id));
          checkOutput("awsize", 64'(awsize), 64'(3'd2));
          checkOutput("awburst", 64'(awburst), 64'(2'b01));
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) failNow("w_unexpected", $sformatf("got wdata 0x%0h, required none", wdata));
        else begin
          w = exp_w.pop_front();
          checkOutput("wdata", 64'(wdata), 64'(w.data));
          checkOutput("wstrb", 64'(wstrb), 64'(w.strb));
          checkOutput("wlast", 64'(wlast), 64'(w.last));
        end
      end
      if (ret_valid) begin
        if (exp_ret.size() == 0) failNow("ret_unexpected", $sformatf("got ret_data 0x%0h, required none", ret_data));
        else begin
          r = exp_ret.pop_front();
          checkOutput("ret_data", 64'(ret_data), 64'(r.data));
          checkOutput("ret_last", 64'(ret_last), 64'(r.last));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus();
    logic        aw_seen, wl_seen, prev_stall, got_b;
    logic [31:0] prev_data;

    // ---------------- reset values ----------------
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_arvalid", 64'(arvalid), 64'(1'b0));
    checkOutput("rst_awvalid", 64'(awvalid), 64'(1'b0));
    checkOutput("rst_wvalid", 64'(wvalid), 64'(1'b0));
    checkOutput("rst_rready", 64'(rready), 64'(1'b0));
    checkOutput("rst_bready", 64'(bready), 64'(1'b0));
    checkOutput("rst_ret_valid", 64'(ret_valid), 64'(1'b0));
    checkOutput("rst_ret_last", 64'(ret_last), 64'(1'b0));
    checkOutput("rst_rd_rdy", 64'(rd_rdy), 64'(1'b1));
    checkOutput("rst_wr_rdy", 64'(wr_rdy), 64'(1'b1));
    @(negedge clk);
    rst = 1'b0;

    // ---------------- line read ----------------
    $display("[TB] line read");
    arready = 1'b1;
    @(negedge clk);
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C00_0014;
    exp_ar.push_back('{32'h1C00_0010, 8'd3, 4'd0});
    #1;
    checkOutput("lr_rd_rdy_idle", 64'(rd_rdy), 64'(1'b1));
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    checkOutput("lr_arvalid_t1", 64'(arvalid), 64'(1'b1));
    checkOutput("lr_rd_rdy_busy", 64'(rd_rdy), 64'(1'b0));
    @(negedge clk);
    #1;
    checkOutput("lr_rready_t2", 64'(rready), 64'(1'b1));
    checkOutput("lr_arvalid_t2", 64'(arvalid), 64'(1'b0));
    rSlave(32'h0000_00A0, 4);
    #1;
    checkOutput("lr_rd_rdy_after", 64'(rd_rdy), 64'(1'b1));
    checkOutput("lr_rready_after", 64'(rready), 64'(1'b0));

    // ---------------- uncached word write ----------------
    $display("[TB] word write");
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'hBFAF_8000;
    wr_wstrb = 4'b0011; wr_data = 128'h1234;
    exp_aw.push_back('{32'hBFAF_8000, 8'd0, 4'd1});
    exp_w.push_back('{32'h0000_1234, 4'b0011, 1'b1});
    @(negedge clk);
    wr_req = 1'b0;
    #1;
    checkOutput("ww_awvalid_t1", 64'(awvalid), 64'(1'b1));
    checkOutput("ww_wvalid_t1", 64'(wvalid), 64'(1'b1));
    checkOutput("ww_wr_rdy_busy", 64'(wr_rdy), 64'(1'b0));
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    #1;
    checkOutput("ww_bready_t2", 64'(bready), 64'(1'b1));
    @(negedge clk);
    #1;
    checkOutput("ww_bready_hold", 64'(bready), 64'(1'b1));
    checkOutput("ww_wr_rdy_resp", 64'(wr_rdy), 64'(1'b0));
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    checkOutput("ww_wr_rdy_after", 64'(wr_rdy), 64'(1'b1));
    checkOutput("ww_bready_after", 64'(bready), 64'(1'b0));

    // ---------------- line write with stalls ----------------
    $display("[TB] line write with stalls");
    @(negedge clk);
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_3008; wr_wstrb = 4'b0001;
    wr_data = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
    exp_aw.push_back('{32'h0000_3000, 8'd3, 4'd1});
    for (int i = 0; i < 4; i++) exp_w.push_back('{32'hDDDD_0000 + 32'(i), 4'hf, (i == 3)});
    aw_seen = 1'b0; wl_seen = 1'b0; prev_stall = 1'b0; got_b = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 40 && !got_b; cyc++) begin
      @(negedge clk);
      wr_req  = 1'b0;
      awready = (cyc >= 5) && !aw_seen;
      wready  = (cyc % 2 == 1);
      #1;
      if (prev_stall) begin
        checkOutput("lw_stall_wvalid", 64'(wvalid), 64'(1'b1));
        checkOutput("lw_stall_wdata", 64'(wdata), 64'(prev_data));
      end
      checkOutput("lw_bready_gate", 64'(bready), 64'(aw_seen && wl_seen));
      if (bready) got_b = 1'b1;
      else begin
        if (awvalid && awready) aw_seen = 1'b1;
        if (wvalid && wready && wlast) wl_seen = 1'b1;
        prev_stall = wvalid && !wready;
        prev_data  = wdata;
      end
    end
    awready = 1'b0; wready = 1'b0;
    if (!got_b) failNow("lw_bready_timeout", "bready never rose");
    bSlave();
    #1;
    checkOutput("lw_wr_rdy_after", 64'(wr_rdy), 64'(1'b1));

    // ---------------- conflict ----------------
    $display("[TB] read/write line conflict");
    awready = 1'b1; wready = 1'b0;
    @(negedge clk);
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_1040;
    wr_data = 128'h000000E3_000000E2_000000E1_000000E0;
    exp_aw.push_back('{32'h0000_1040, 8'd3, 4'd1});
    for (int i = 0; i < 4; i++) exp_w.push_back('{32'h0000_00E0 + 32'(i), 4'hf, (i == 3)});
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_104C;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("cf_blocked", 64'(rd_rdy), 64'(1'b0));
      @(negedge clk);
    end
    rd_addr = 32'h0000_2000;
    #1;
    checkOutput("cf_other_line", 64'(rd_rdy), 64'(1'b1));
    exp_ar.push_back('{32'h0000_2000, 8'd3, 4'd0});
    @(negedge clk);
    rd_req = 1'b0;
    rSlave(32'h0000_00B0, 4);
    rd_req = 1'b1; rd_addr = 32'h0000_104C;
    wready = 1'b1;
    for (int c = 0; c < 20 && !bready; c++) begin
      #1;
      checkOutput("cf_blocked_xfer", 64'(rd_rdy), 64'(1'b0));
      @(negedge clk);
    end
    wready = 1'b0; awready = 1'b0;
    #1;
    if (!bready) failNow("cf_bready_timeout", "bready never rose");
    bvalid = 1'b1;
    checkOutput("cf_blocked_resp", 64'(rd_rdy), 64'(1'b0));
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    checkOutput("cf_released", 64'(rd_rdy), 64'(1'b1));
    exp_ar.push_back('{32'h0000_1040, 8'd3, 4'd0});
    @(negedge clk);
    rd_req = 1'b0;
    rSlave(32'h0000_00C0, 4);

    // ---------------- concurrent read + write ----------------
    $display("[TB] concurrent read and write");
    @(negedge clk);
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_5000;
    wr_data = 128'h000000F3_000000F2_000000F1_000000F0;
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_6004;
    exp_aw.push_back('{32'h0000_5000, 8'd3, 4'd1});
    for (int i = 0; i < 4; i++) exp_w.push_back('{32'h0000_00F0 + 32'(i), 4'hf, (i == 3)});
    exp_ar.push_back('{32'h0000_6004, 8'd0, 4'd0});
    #1;
    checkOutput("cc_rd_rdy", 64'(rd_rdy), 64'(1'b1));
    checkOutput("cc_wr_rdy", 64'(wr_rdy), 64'(1'b1));
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    fork
      rSlave(32'h0000_0077, 1);
      writeFinish();
    join
    #1;
    checkOutput("cc_rd_rdy_after", 64'(rd_rdy), 64'(1'b1));
    checkOutput("cc_wr_rdy_after", 64'(wr_rdy), 64'(1'b1));

    // ---------------- reset mid-burst ----------------
    $display("[TB] reset during read burst");
    awready = 1'b0; wready = 1'b0;
    @(negedge clk);
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_7000;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_8000;
    exp_ar.push_back('{32'h0000_7000, 8'd3, 4'd0});
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    waitFor(SIG_RREADY, "rst_rready_wait", 20);
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'h0000_00D0 + 32'(i); rlast = 1'b0;
      exp_ret.push_back('{32'h0000_00D0 + 32'(i), 1'b0});
      @(negedge clk);
    end
    rst = 1'b1;
    rvalid = 1'b1; rdata = 32'h0000_00D2; rlast = 1'b0;
    exp_ret.push_back('{32'h0000_00D2, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'h0000_00D3; rlast = 1'b1;
    #1;
    checkOutput("mr_rready", 64'(rready), 64'(1'b0));
    checkOutput("mr_ret_valid", 64'(ret_valid), 64'(1'b0));
    checkOutput("mr_ret_last", 64'(ret_last), 64'(1'b0));
    checkOutput("mr_rd_rdy", 64'(rd_rdy), 64'(1'b1));
    checkOutput("mr_wr_rdy", 64'(wr_rdy), 64'(1'b1));
    checkOutput("mr_awvalid", 64'(awvalid), 64'(1'b0));
    checkOutput("mr_wvalid", 64'(wvalid), 64'(1'b0));
    checkOutput("mr_arvalid", 64'(arvalid), 64'(1'b0));
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("left_ar", 64'(exp_ar.size()), 64'(0));
    checkOutput("left_aw", 64'(exp_aw.size()), 64'(0));
    checkOutput("left_w", 64'(exp_w.size()), 64'(0));
    checkOutput("left_ret", 64'(exp_ret.size()), 64'(0));
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
